buzzer_note_sequencer: RTL and testbench

//  Command-driven note scheduler placed in front of the buzzer sound generator (soundGen).

---
 rtl/buzzer_note_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_buzzer_note_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | buzzer_note_sequencer: FIFO-buffered note scheduler feeding soundGen.       |
// | Optional inter-note silence gap: define BUZZER_SEQ_GAP_EN.  Rev 1.0         |
// +----------------------------------------------------------------------------+
module buzzer_note_sequencer #(
    parameter int DEPTH     = 16,
    parameter int DUR_W     = 12,
    parameter int GAP_TICKS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freq,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_gen,
    input  logic [7:0]               cmd_sound,
    input  logic [DUR_W-1:0]         cmd_dur,
    input  logic                     flush,
    output logic [2:0]               note_gen,
    output logic [7:0]               note_sound,
    output logic                     note_start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int ENTRY_W = 3 + 8 + DUR_W;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_play = 2'd2;
`ifdef BUZZER_SEQ_GAP_EN
    localparam logic [1:0] c_st_gap  = 2'd3;
    localparam int GAP_W = $clog2(GAP_TICKS + 2);
    localparam logic [GAP_W-1:0] c_gap_init = (GAP_TICKS == 0) ? GAP_W'(1) : GAP_W'(GAP_TICKS);
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         note_gen_q, note_gen_d;
    logic [7:0]         note_sound_q, note_sound_d;
    logic               note_start_q, note_start_d;
    logic               done_q, done_d;
`ifdef BUZZER_SEQ_GAP_EN
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`endif

    logic               w_push, w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [DUR_W-1:0]   w_head_dur;

    // No bypass: a full FIFO refuses even when LOAD pops in the same cycle.
    assign cmd_ready  = (level_q != LW'(DEPTH)) && !flush;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (state_q == c_st_load) && (level_q != '0) && !flush;
    assign w_head     = mem_q[rd_ptr_q];
    assign w_head_dur = w_head[DUR_W-1:0];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        note_gen_d   = note_gen_q;
        note_sound_d = note_sound_q;
        note_start_d = 1'b0;
        done_d       = 1'b0;
`ifdef BUZZER_SEQ_GAP_EN
        gap_cnt_d    = gap_cnt_q;
`endif
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

        case (state_q)
            c_st_idle: begin
                if (level_q != '0) state_d = c_st_load;
            end
            c_st_load: begin
                if (level_q != '0) begin
                    note_gen_d   = w_head[ENTRY_W-1 -: 3];
                    note_sound_d = w_head[DUR_W +: 8];
                    note_start_d = 1'b1;
                    cnt_d        = (w_head_dur == '0) ? DUR_W'(1) : w_head_dur;
                    state_d      = c_st_play;
                end else begin
                    state_d = c_st_idle;
                end
            end
            c_st_play: begin
                if (freq) begin
                    if (cnt_q == DUR_W'(1)) begin
                        cnt_d = '0;
                        if (level_q != '0) begin
`ifdef BUZZER_SEQ_GAP_EN
                            note_gen_d   = 3'd0;
                            note_sound_d = 8'd0;
                            note_start_d = 1'b1;
                            gap_cnt_d    = c_gap_init;
                            state_d      = c_st_gap;
`else
                            state_d = c_st_load;
`endif
                        end else begin
                            note_gen_d   = 3'd0;
                            note_sound_d = 8'd0;
                            note_start_d = 1'b1;
                            done_d       = 1'b1;
                            state_d      = c_st_idle;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
`ifdef BUZZER_SEQ_GAP_EN
            c_st_gap: begin
                if (freq) begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        gap_cnt_d = '0;
                        state_d   = c_st_load;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
            end
`endif
            default: state_d = c_st_idle;
        endcase

        // Flush overrides everything: drop queue and note, emit silence without done.
        if (flush) begin
            rd_ptr_d     = wr_ptr_q;
            wr_ptr_d     = wr_ptr_q;
            level_d      = '0;
            cnt_d        = '0;
            note_gen_d   = 3'd0;
            note_sound_d = 8'd0;
            note_start_d = 1'b1;
            done_d       = 1'b0;
            state_d      = c_st_idle;
`ifdef BUZZER_SEQ_GAP_EN
            gap_cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= {cmd_gen, cmd_sound, cmd_dur};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_st_idle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            note_gen_q   <= '0;
            note_sound_q <= '0;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef BUZZER_SEQ_GAP_EN
            gap_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            note_gen_q   <= note_gen_d;
            note_sound_q <= note_sound_d;
            note_start_q <= note_start_d;
            done_q       <= done_d;
`ifdef BUZZER_SEQ_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    assign note_gen   = note_gen_q;
    assign note_sound = note_sound_q;
    assign note_start = note_start_q;
    assign done       = done_q;
    assign busy       = (state_q != c_st_idle);
    assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_buzzer_note_sequencer: directed self-checking bench for the sequencer.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_buzzer_note_sequencer;

    localparam int DEPTH = 16;
    localparam int DUR_W = 12;

    logic             clk = 1'b0;
    logic             rst, freq, cmd_valid, flush;
    logic             cmd_ready;
    logic [2:0]       cmd_gen;
    logic [7:0]       cmd_sound;
    logic [DUR_W-1:0] cmd_dur;
    logic [2:0]       note_gen;
    logic [7:0]       note_sound;
    logic             note_start, busy, done;
    logic [4:0]       fifo_level;

    int checks = 0;
    int errors = 0;

    buzzer_note_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .GAP_TICKS(2)) dut (
        .clk(clk), .rst(rst), .freq(freq), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_gen(cmd_gen), .cmd_sound(cmd_sound), .cmd_dur(cmd_dur), .flush(flush),
        .note_gen(note_gen), .note_sound(note_sound), .note_start(note_start),
        .busy(busy), .done(done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [2:0] g, input logic [7:0] s, input logic [DUR_W-1:0] d);
        cmd_valid = 1'b1;
        cmd_gen   = g;
        cmd_sound = s;
        cmd_dur   = d;
    endtask

    task automatic pulse_freq();
        freq = 1'b1;
        step();
        freq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freq = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
        cmd_gen = '0; cmd_sound = '0; cmd_dur = '0;
        step(); step();
        chk("rst_start", note_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sound", note_sound, 0);
        chk("rst_gen", note_gen, 0);
        rst = 1'b0;
        step();

        // Single note: accept, two edges later note_start, three ticks to silence.
        set_cmd(3'd1, 8'hD5, 12'd3);
        step();
        cmd_valid = 1'b0;
        chk("t1_level_after_push", fifo_level, 1);
        chk("t1_no_start_yet", note_start, 0);
        step();
        chk("t1_busy_load", busy, 1);
        chk("t1_no_start_load", note_start, 0);
        step();
        chk("t1_start", note_start, 1);
        chk("t1_sound", note_sound, 8'hD5);
        chk("t1_gen", note_gen, 1);
        chk("t1_level_popped", fifo_level, 0);
        step();
        chk("t1_start_one_cycle", note_start, 0);
        pulse_freq();
        step();
        pulse_freq();
        chk("t1_not_done_2ticks", done, 0);
        chk("t1_still_busy", busy, 1);
        pulse_freq();
        chk("t1_silence_start", note_start, 1);
        chk("t1_done", done, 1);
        chk("t1_silence_sound", note_sound, 0);
        chk("t1_silence_gen", note_gen, 0);
        chk("t1_idle", busy, 0);
        step();
        chk("t1_done_one_cycle", done, 0);

        // Fill: first command moves into PLAY, sixteen more fill the FIFO.
        for (int i = 0; i < 17; i++) begin
            set_cmd(3'd2, 8'h40 + 8'(i), 12'd1);
            step();
        end
        chk("t2_level_full", fifo_level, 16);
        chk("t2_ready_full", cmd_ready, 0);
        set_cmd(3'd2, 8'hEE, 12'd1);
        step();
        chk("t2_extra_refused", fifo_level, 16);
        cmd_valid = 1'b0;
        pulse_freq();
        #1;
        chk("t2_no_bypass_ready", cmd_ready, 0);
        step();
        chk("t2_ready_after_pop", cmd_ready, 1);
        chk("t2_level_after_pop", fifo_level, 15);
        chk("t2_second_sound", note_sound, 8'h41);
        chk("t2_second_start", note_start, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t2_flush_level", fifo_level, 0);
        chk("t2_flush_start", note_start, 1);
        chk("t2_flush_done", done, 0);
        step();

`ifndef BUZZER_SEQ_GAP_EN
        // Legato pair: dur 2 then dur 0 (treated as 1).
        set_cmd(3'd2, 8'h11, 12'd2);
        step();
        set_cmd(3'd3, 8'h22, 12'd0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t3_a_start", note_start, 1);
        chk("t3_a_sound", note_sound, 8'h11);
        step();
        pulse_freq();
        step();
        pulse_freq();
        chk("t3_load_no_start", note_start, 0);
        chk("t3_load_no_done", done, 0);
        chk("t3_load_busy", busy, 1);
        step();
        chk("t3_b_start", note_start, 1);
        chk("t3_b_sound", note_sound, 8'h22);
        chk("t3_b_gen", note_gen, 3);
        step();
        pulse_freq();
        chk("t3_b_end_done", done, 1);
        chk("t3_b_end_silence", note_sound, 0);
        step();
        chk("t3_done_single", done, 0);
`else
        // Gap build: silence pulse between notes, then two gap ticks.
        set_cmd(3'd0, 8'h31, 12'd1);
        step();
        set_cmd(3'd1, 8'h32, 12'd1);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t6_n1_sound", note_sound, 8'h31);
        step();
        pulse_freq();
        chk("t6_gap_silence_start", note_start, 1);
        chk("t6_gap_silence_sound", note_sound, 0);
        chk("t6_gap_no_done", done, 0);
        chk("t6_gap_busy", busy, 1);
        step();
        pulse_freq();
        chk("t6_gap_tick1_no_start", note_start, 0);
        pulse_freq();
        chk("t6_gap_load_no_start", note_start, 0);
        step();
        chk("t6_n2_start", note_start, 1);
        chk("t6_n2_sound", note_sound, 8'h32);
        step();
        pulse_freq();
        chk("t6_done", done, 1);
        step();
`endif

        // Flush mid-note with three queued and a push attempted in the flush cycle.
        for (int i = 0; i < 4; i++) begin
            set_cmd(3'd5, 8'h60 + 8'(i), 12'd5);
            step();
        end
        chk("t4_level3", fifo_level, 3);
        chk("t4_playing", busy, 1);
        set_cmd(3'd5, 8'h99, 12'd5);
        flush = 1'b1;
        #1;
        chk("t4_ready_in_flush", cmd_ready, 0);
        step();
        flush = 1'b0;
        cmd_valid = 1'b0;
        chk("t4_level0", fifo_level, 0);
        chk("t4_silence_start", note_start, 1);
        chk("t4_silence_sound", note_sound, 0);
        chk("t4_idle", busy, 0);
        chk("t4_no_done", done, 0);
        step();
        chk("t4_no_second_pulse", note_start, 0);
        chk("t4_done_stays0", done, 0);
        chk("t4_level_stays0", fifo_level, 0);

        // Asynchronous reset mid-note, then normal playback.
        set_cmd(3'd3, 8'h77, 12'd4);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t5_playing_sound", note_sound, 8'h77);
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_sound", note_sound, 0);
        chk("t5_rst_gen", note_gen, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_start", note_start, 0);
        step();
        chk("t5_rst_no_pulse", note_start, 0);
        chk("t5_rst_no_done", done, 0);
        rst = 1'b0;
        step();
        set_cmd(3'd4, 8'h5A, 12'd1);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t5_new_start", note_start, 1);
        chk("t5_new_sound", note_sound, 8'h5A);
        chk("t5_new_gen", note_gen, 4);
        step();
        pulse_freq();
        chk("t5_new_done", done, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
